// File: rtl/logit_vote_pkg.sv
// Shared types and width helpers for the logit vote decoder and its argmax scanner.
package logit_vote_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SCAN,
    VOTE,
    EMIT
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int margin_width(input int nbits);
    return nbits + 1;
  endfunction

endpackage

// File: rtl/logit_vote_decoder_argmax_scan.sv
// Serial signed argmax: tracks best, second-best and winning index, one element per cycle.
module argmax_scan
  import logit_vote_pkg::*;
#(
  parameter int NClasses = 3,
  parameter int NBits    = 12,
  parameter int IW       = idx_width(NClasses)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start,
  input  logic signed [NBits-1:0] first_in,
  input  logic signed [NBits-1:0] elem_in,
  output logic        [IW-1:0]    elem_idx,
  output logic                    done,
  output logic signed [NBits-1:0] best,
  output logic signed [NBits-1:0] second,
  output logic        [IW-1:0]    idx
);

  localparam logic signed [NBits-1:0] MostNeg = {1'b1, {(NBits-1){1'b0}}};

  logic          active_q;
  logic [IW-1:0] i_q;

  assign elem_idx = i_q;
  assign done     = active_q && (i_q == IW'(NClasses - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active_q <= 1'b0;
      i_q      <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      i_q      <= IW'(1);
    end else if (active_q) begin
      if (done) active_q <= 1'b0;
      else      i_q      <= i_q + IW'(1);
    end
  end

  // Strict compares so equal values never displace the lower index.
  always_ff @(posedge clk_in) begin
    if (start) begin
      best   <= first_in;
      second <= MostNeg;
      idx    <= '0;
    end else if (active_q) begin
      if (elem_in > best) begin
        second <= best;
        best   <= elem_in;
        idx    <= i_q;
      end else if (elem_in > second) begin
        second <= elem_in;
      end
    end
  end

endmodule

// File: rtl/logit_vote_decoder.sv
// Drains logit vectors, picks the argmax, debounces it by vote and emits class changes.
// Optional margin gating (abstain on low top-two gap) is enabled by LOGIT_VOTE_MARGIN_EN.
module logit_vote_decoder
  import logit_vote_pkg::*;
#(
  parameter int NClasses  = 3,
  parameter int NBits     = 12,
  parameter int VoteDepth = 4,
  parameter int MinMargin = 8
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 in_vec_valid,
  input  logic [NClasses-1:0][NBits-1:0]       in_logits,
  output logic                                 rd_out,
  output logic                                 cmd_valid,
  input  logic                                 cmd_ready,
  output logic [idx_width(NClasses)-1:0]       cmd_class,
  output logic [margin_width(NBits)-1:0]       cmd_margin,
  output logic                                 busy
);

  localparam int IW = idx_width(NClasses);
  localparam int MW = margin_width(NBits);
  localparam int CW = $clog2(VoteDepth + 1);

`ifdef LOGIT_VOTE_MARGIN_EN
  localparam bit MarginGate = 1'b1;
`else
  localparam bit MarginGate = 1'b0;
`endif

  state_t state_q, state_d;

  logic [NClasses-1:0][NBits-1:0] vec_p0;
  logic [IW-1:0]                  cand_q, cand_nxt;
  logic [CW-1:0]                  count_q, cnt_nxt;
  logic                           issued_q;
  logic [IW-1:0]                  cmd_class_q;
  logic [MW-1:0]                  cmd_margin_q;

  logic                    scan_start, scan_done;
  logic [IW-1:0]           scan_elem_idx, win_idx;
  logic signed [NBits-1:0] scan_elem, win_best, win_second;
  logic signed [MW-1:0]    margin_s;
  logic [MW-1:0]           margin_u;
  logic                    abstain, emit_ok;

  // Capture stage: one-cycle FIFO read latency, data only
  always_ff @(posedge clk_in) begin
    if (state_q == CAPT) vec_p0 <= in_logits;
  end

  assign scan_start = (state_q == CAPT);
  assign scan_elem  = $signed(vec_p0[scan_elem_idx]);

  argmax_scan #(
    .NClasses(NClasses),
    .NBits   (NBits),
    .IW      (IW)
  ) u_scan (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start   (scan_start),
    .first_in($signed(in_logits[0])),
    .elem_in (scan_elem),
    .elem_idx(scan_elem_idx),
    .done    (scan_done),
    .best    (win_best),
    .second  (win_second),
    .idx     (win_idx)
  );

  // Vote stage: both operands sign-extended, so the gap cannot overflow
  assign margin_s = $signed({win_best[NBits-1], win_best}) - $signed({win_second[NBits-1], win_second});
  assign margin_u = $unsigned(margin_s);

  always_comb begin
    abstain  = MarginGate && (margin_u < MW'(MinMargin));
    cand_nxt = cand_q;
    cnt_nxt  = count_q;
    if (abstain) begin
      cnt_nxt = '0;
    end else if (win_idx == cand_q) begin
      cnt_nxt = (count_q >= CW'(VoteDepth)) ? count_q : count_q + CW'(1);
    end else begin
      cand_nxt = win_idx;
      cnt_nxt  = CW'(1);
    end
    emit_ok = !abstain && (cnt_nxt == CW'(VoteDepth)) && (!issued_q || (cand_nxt != cmd_class_q));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_vec_valid) state_d = READ;
      READ:    state_d = CAPT;
      CAPT:    state_d = SCAN;
      SCAN:    if (scan_done) state_d = VOTE;
      VOTE:    state_d = emit_ok ? EMIT : IDLE;
      EMIT:    if (cmd_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      count_q      <= '0;
      issued_q     <= 1'b0;
      cmd_class_q  <= '0;
      cmd_margin_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == VOTE) begin
        cand_q  <= cand_nxt;
        count_q <= cnt_nxt;
        if (emit_ok) begin
          cmd_class_q  <= cand_nxt;
          cmd_margin_q <= margin_u;
        end
      end
      if ((state_q == EMIT) && cmd_ready) issued_q <= 1'b1;
    end
  end

  assign rd_out     = (state_q == READ);
  assign cmd_valid  = (state_q == EMIT);
  assign busy       = (state_q != IDLE);
  assign cmd_class  = cmd_class_q;
  assign cmd_margin = cmd_margin_q;

endmodule

// File: tb/tb_logit_vote_decoder.sv
// Directed bench for logit_vote_decoder: three instances with VoteDepth 1, 3 and 2.
module tb_logit_vote_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             vv;
  logic             rdy;
  int               sel;
  logic [2:0][11:0] logits;

  logic vv1, vv2, vv3, rdy1, rdy2, rdy3;
  logic rd1, rd2, rd3, cv1, cv2, cv3, busy1, busy2, busy3;
  logic [1:0]  cls1, cls2, cls3;
  logic [12:0] mar1, mar2, mar3;

  assign vv1  = vv  && (sel == 1);
  assign vv2  = vv  && (sel == 2);
  assign vv3  = vv  && (sel == 3);
  assign rdy1 = rdy && (sel == 1);
  assign rdy2 = rdy && (sel == 2);
  assign rdy3 = rdy && (sel == 3);

  logit_vote_decoder #(.NClasses(3), .NBits(12), .VoteDepth(1), .MinMargin(8)) u_d1 (
    .clk_in(clk), .rst_in(rst), .in_vec_valid(vv1), .in_logits(logits), .rd_out(rd1),
    .cmd_valid(cv1), .cmd_ready(rdy1), .cmd_class(cls1), .cmd_margin(mar1), .busy(busy1));
  logit_vote_decoder #(.NClasses(3), .NBits(12), .VoteDepth(2), .MinMargin(8)) u_d2 (
    .clk_in(clk), .rst_in(rst), .in_vec_valid(vv2), .in_logits(logits), .rd_out(rd2),
    .cmd_valid(cv2), .cmd_ready(rdy2), .cmd_class(cls2), .cmd_margin(mar2), .busy(busy2));
  logit_vote_decoder #(.NClasses(3), .NBits(12), .VoteDepth(3), .MinMargin(8)) u_d3 (
    .clk_in(clk), .rst_in(rst), .in_vec_valid(vv3), .in_logits(logits), .rd_out(rd3),
    .cmd_valid(cv3), .cmd_ready(rdy3), .cmd_class(cls3), .cmd_margin(mar3), .busy(busy3));

  logic        s_rd, s_cv, s_busy;
  logic [1:0]  s_cls;
  logic [12:0] s_mar;
  always_comb begin
    s_rd = rd1; s_cv = cv1; s_busy = busy1; s_cls = cls1; s_mar = mar1;
    if (sel == 2) begin
      s_rd = rd2; s_cv = cv2; s_busy = busy2; s_cls = cls2; s_mar = mar2;
    end else if (sel == 3) begin
      s_rd = rd3; s_cv = cv3; s_busy = busy3; s_cls = cls3; s_mar = mar3;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Drives one vector with in_vec_valid held high; stops at cmd_valid or return to idle.
  task automatic frame(input int a, input int b, input int c,
                       output int rd_cnt, output int rd_cyc, output int cv_cyc);
    logits[0] = a[11:0];
    logits[1] = b[11:0];
    logits[2] = c[11:0];
    vv = 1'b1;
    rd_cnt = 0; rd_cyc = -1; cv_cyc = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (s_rd) begin rd_cnt++; rd_cyc = cyc; end
      if (s_cv) begin cv_cyc = cyc; break; end
      if (!s_busy) break;
    end
    vv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vv = 1'b0; rdy = 1'b0; sel = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if ({rd1, cv1, busy1, cls1, mar1} !== 18'd0) begin n_bad++; $display("FAIL reset_d1 got %h want 0", {rd1, cv1, busy1, cls1, mar1}); end
    n_cmp++; if ({rd2, cv2, busy2, cls2, mar2} !== 18'd0) begin n_bad++; $display("FAIL reset_d2 got %h want 0", {rd2, cv2, busy2, cls2, mar2}); end
    n_cmp++; if ({rd3, cv3, busy3, cls3, mar3} !== 18'd0) begin n_bad++; $display("FAIL reset_d3 got %h want 0", {rd3, cv3, busy3, cls3, mar3}); end
  endtask

  task automatic handshake(input string name, input logic [1:0] ecls, input logic [12:0] emar);
    n_cmp++; if (s_cls !== ecls) begin n_bad++; $display("FAIL %s_class got %0d want %0d", name, s_cls, ecls); end
    n_cmp++; if (s_mar !== emar) begin n_bad++; $display("FAIL %s_margin got %0d want %0d", name, s_mar, emar); end
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    n_cmp++; if ({s_cv, s_busy} !== 2'b00) begin n_bad++; $display("FAIL %s_after_hs got cv/busy %b want 00", name, {s_cv, s_busy}); end
    n_cmp++; if (s_cls !== ecls || s_mar !== emar) begin n_bad++; $display("FAIL %s_hold got %0d/%0d want %0d/%0d", name, s_cls, s_mar, ecls, emar); end
  endtask

  task automatic test_basic();
    int rc, ry, cy;
    sel = 1;
    frame(10, -5, 3, rc, ry, cy);
    n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL basic_rd_count got %0d want 1", rc); end
    n_cmp++; if (ry !== 1) begin n_bad++; $display("FAIL basic_rd_cycle got %0d want 1", ry); end
    n_cmp++; if (cy !== 6) begin n_bad++; $display("FAIL basic_cv_cycle got %0d want 6", cy); end
    handshake("basic", 2'd0, 13'd7);
    frame(-100, -3, -50, rc, ry, cy);
    n_cmp++; if (cy !== 6) begin n_bad++; $display("FAIL neg_cv_cycle got %0d want 6", cy); end
    handshake("neg", 2'd1, 13'd47);
  endtask

  task automatic test_tie();
    int rc, ry, cy;
    sel = 1;
    frame(7, 7, -2, rc, ry, cy);
    n_cmp++; if (cy !== 6) begin n_bad++; $display("FAIL tie_cv_cycle got %0d want 6", cy); end
    handshake("tie", 2'd0, 13'd0);
  endtask

  task automatic test_vote();
    int rc, ry, cy, extra;
    int win[6] = '{2, 2, 1, 2, 2, 2};
    sel = 3;
    for (int f = 0; f < 6; f++) begin
      if (win[f] == 2) frame(0, 1, 5, rc, ry, cy);
      else             frame(0, 9, 1, rc, ry, cy);
      if (f < 5) begin
        n_cmp++; if (cy !== -1) begin n_bad++; $display("FAIL vote_early_frame%0d cv_cycle got %0d want none", f, cy); end
      end
    end
    n_cmp++; if (cy !== 6) begin n_bad++; $display("FAIL vote_confirm cv_cycle got %0d want 6", cy); end
    handshake("vote", 2'd2, 13'd4);
    extra = 0;
    for (int f = 0; f < 10; f++) begin
      frame(0, 1, 5, rc, ry, cy);
      if (cy != -1) begin
        extra++;
        rdy = 1'b1; @(posedge clk); #1; rdy = 1'b0;
      end
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL vote_repeat extra cmds got %0d want 0", extra); end
  endtask

  task automatic test_backpressure();
    int rc, ry, cy, unstable, rd_seen;
    sel = 1;
    frame(1, 20, 2, rc, ry, cy);
    n_cmp++; if (cy !== 6) begin n_bad++; $display("FAIL bp_cv_cycle got %0d want 6", cy); end
    vv = 1'b1; unstable = 0; rd_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (!s_cv || !s_busy || s_cls != 2'd1 || s_mar != 13'd18) unstable++;
      if (s_rd) rd_seen++;
    end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_stable unstable cycles got %0d want 0", unstable); end
    n_cmp++; if (rd_seen !== 0) begin n_bad++; $display("FAIL bp_rd rd pulses got %0d want 0", rd_seen); end
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0; vv = 1'b0;
    n_cmp++; if ({s_cv, s_busy} !== 2'b00) begin n_bad++; $display("FAIL bp_release got cv/busy %b want 00", {s_cv, s_busy}); end
    n_cmp++; if (s_cls !== 2'd1 || s_mar !== 13'd18) begin n_bad++; $display("FAIL bp_hold got %0d/%0d want 1/18", s_cls, s_mar); end
  endtask

  task automatic test_margin();
    int rc, ry, cy;
    sel = 2;
`ifdef LOGIT_VOTE_MARGIN_EN
    frame(100, 95, 0, rc, ry, cy);
    n_cmp++; if (cy !== -1) begin n_bad++; $display("FAIL margin_abstain1 cv_cycle got %0d want none", cy); end
    frame(100, 95, 0, rc, ry, cy);
    n_cmp++; if (cy !== -1) begin n_bad++; $display("FAIL margin_abstain2 cv_cycle got %0d want none", cy); end
    frame(100, 50, 0, rc, ry, cy);
    n_cmp++; if (cy !== -1) begin n_bad++; $display("FAIL margin_first_vote cv_cycle got %0d want none", cy); end
    frame(100, 50, 0, rc, ry, cy);
    n_cmp++; if (cy !== 6) begin n_bad++; $display("FAIL margin_confirm cv_cycle got %0d want 6", cy); end
    handshake("margin", 2'd0, 13'd50);
`else
    frame(100, 95, 0, rc, ry, cy);
    n_cmp++; if (cy !== -1) begin n_bad++; $display("FAIL nogate_first_vote cv_cycle got %0d want none", cy); end
    frame(100, 95, 0, rc, ry, cy);
    n_cmp++; if (cy !== 6) begin n_bad++; $display("FAIL nogate_confirm cv_cycle got %0d want 6", cy); end
    handshake("nogate", 2'd0, 13'd5);
    frame(100, 50, 0, rc, ry, cy);
    n_cmp++; if (cy !== -1) begin n_bad++; $display("FAIL nogate_same_class cv_cycle got %0d want none", cy); end
`endif
  endtask

  task automatic test_reset_mid();
    int rc, ry, cy;
    sel = 1;
    frame(0, 1, 5, rc, ry, cy);
    n_cmp++; if (cy !== 6) begin n_bad++; $display("FAIL rstmid_cv_cycle got %0d want 6", cy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if ({s_cv, s_busy} !== 2'b00) begin n_bad++; $display("FAIL rstmid_ctrl got cv/busy %b want 00", {s_cv, s_busy}); end
    n_cmp++; if (s_cls !== 2'd0 || s_mar !== 13'd0) begin n_bad++; $display("FAIL rstmid_data got %0d/%0d want 0/0", s_cls, s_mar); end
    frame(5, 1, 0, rc, ry, cy);
    n_cmp++; if (cy !== 6) begin n_bad++; $display("FAIL rstmid_reissue cv_cycle got %0d want 6", cy); end
    handshake("rstmid", 2'd0, 13'd4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logits = '0;
    test_reset();
    test_basic();
    test_tie();
    test_vote();
    test_backpressure();
    test_margin();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
